// File: rtl/alu_ctrl_issue_if.sv
// Request, ALU-drive and response signals between the issue controller and its neighbours.
// slave = the controller's view; master = the driving environment's view.
interface alu_ctrl_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_aluctl;
    logic [5:0]  req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_ina;
    logic [31:0] alu_inb;
    logic [3:0]  alu_aluop;
    logic        alu_reset;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_aluctl, req_funct, req_shamt, req_a, req_b,
        input  alu_result, alu_zero, rsp_ready,
        output req_ready, alu_ina, alu_inb, alu_aluop, alu_reset,
        output rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_aluctl, req_funct, req_shamt, req_a, req_b,
        output alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_ina, alu_inb, alu_aluop, alu_reset,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ALU issue controller: queues decoded requests, drives the ALU port ina/aluop then inb, captures after SETTLE.
// Optional macro ALU_SLT_EN makes funct 0x2A (slt) legal, with the compare computed in-block.
module alu_ctrl_issue #(
    parameter int DEPTH  = 2,
    parameter int SETTLE = 1
) (
    input logic             clk,
    input logic             reset,
    alu_ctrl_issue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [1:0]  aluctl;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_settle;
    logic          r_alu_reset;
    logic [31:0]   r_alu_ina, r_alu_inb, r_inb_pend;
    logic [3:0]    r_alu_aluop;
    logic          r_rsp_valid, r_rsp_zero, r_rsp_err;
    logic [31:0]   r_rsp_result;

    req_t        w_head;
    logic        w_push, w_pop, w_launch, w_capture, w_done;
    logic        w_legal, w_sll;
    logic [3:0]  w_code;
    logic [31:0] w_op_ina, w_op_inb, w_cap_result;
    logic        w_cap_zero;

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.req_ready = !r_alu_reset && (r_count != CW'(DEPTH));
    assign w_push        = bus.req_valid && bus.req_ready;

    always_comb begin
        w_legal = 1'b0;
        w_sll   = 1'b0;
        w_code  = OP_ADD;
        case (w_head.aluctl)
            2'b00: w_legal = 1'b1;
            2'b01: begin w_legal = 1'b1; w_code = OP_SUB; end
            2'b10: begin
                case (w_head.funct)
                    6'h20: w_legal = 1'b1;
                    6'h22: begin w_legal = 1'b1; w_code = OP_SUB; end
                    6'h24: begin w_legal = 1'b1; w_code = OP_AND; end
                    6'h25: begin w_legal = 1'b1; w_code = OP_OR;  end
                    6'h00: begin w_legal = 1'b1; w_code = OP_SLL; w_sll = 1'b1; end
`ifdef ALU_SLT_EN
                    6'h2A: begin w_legal = 1'b1; w_code = OP_SUB; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // SLL shifts rt by shamt, so the operands swap roles on the ALU port.
    assign w_op_ina = w_sll ? w_head.b : w_head.a;
    assign w_op_inb = w_sll ? {27'b0, w_head.shamt} : w_head.b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0) begin
                w_pop       = 1'b1;
                w_state_nxt = w_legal ? S_LAUNCH : S_RESP;
            end
            S_LAUNCH: begin
                w_launch    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (r_settle == SW'(1)) begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ALU_SLT_EN
    logic r_is_slt;
    logic w_slt, w_slt_lt;
    assign w_slt    = (w_head.aluctl == 2'b10) && (w_head.funct == 6'h2A);
    assign w_slt_lt = $signed(r_alu_ina) < $signed(r_alu_inb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_is_slt <= 1'b0;
        else if (w_pop && w_legal)  r_is_slt <= w_slt;
    end

    assign w_cap_result = r_is_slt ? {31'b0, w_slt_lt} : bus.alu_result;
    assign w_cap_zero   = r_is_slt ? !w_slt_lt : bus.alu_zero;
`else
    assign w_cap_result = bus.alu_result;
    assign w_cap_zero   = bus.alu_zero;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{bus.req_aluctl, bus.req_funct, bus.req_shamt, bus.req_a, bus.req_b};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_settle     <= '0;
            r_alu_reset  <= 1'b1;
            r_alu_ina    <= '0;
            r_alu_inb    <= '0;
            r_inb_pend   <= '0;
            r_alu_aluop  <= 4'b0000;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_alu_reset <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_pop && w_legal) begin
                r_alu_ina   <= w_op_ina;
                r_alu_aluop <= w_code;
                r_inb_pend  <= w_op_inb;
            end
            if (w_pop && !w_legal) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= '0;
                r_rsp_zero   <= 1'b0;
                r_rsp_err    <= 1'b1;
            end
            if (w_launch) begin
                r_alu_inb <= r_inb_pend;
                r_settle  <= SW'(SETTLE);
            end else if (r_state == S_WAIT) begin
                r_settle  <= r_settle - 1'b1;
            end
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_cap_result;
                r_rsp_zero   <= w_cap_zero;
                r_rsp_err    <= 1'b0;
            end
            if (w_done) r_rsp_valid <= 1'b0;
        end
    end

    assign bus.alu_ina    = r_alu_ina;
    assign bus.alu_inb    = r_alu_inb;
    assign bus.alu_aluop  = r_alu_aluop;
    assign bus.alu_reset  = r_alu_reset;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue (DEPTH=2, SETTLE=1) with a behavioural combinational ALU on the port.
module tb_alu_ctrl_issue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_ctrl_issue_if bus();

    alu_ctrl_issue #(.DEPTH(2), .SETTLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] alu_r;
    always_comb begin
        alu_r = 32'h0;
        if (!bus.alu_reset) begin
            case (bus.alu_aluop)
                4'b0000: alu_r = bus.alu_ina & bus.alu_inb;
                4'b0001: alu_r = bus.alu_ina | bus.alu_inb;
                4'b0010: alu_r = bus.alu_ina + bus.alu_inb;
                4'b0110: alu_r = bus.alu_ina - bus.alu_inb;
                4'b1000: alu_r = bus.alu_ina << bus.alu_inb[4:0];
                default: alu_r = 32'h0;
            endcase
        end
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_zero   = (alu_r == 32'h0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ctl, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b);
        bus.req_valid  = 1'b1;
        bus.req_aluctl = ctl;
        bus.req_funct  = fn;
        bus.req_shamt  = sh;
        bus.req_a      = a;
        bus.req_b      = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        chk("push_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] res, input logic zero, input logic err);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
        chk({tag, "_valid"},  {31'b0, bus.rsp_valid}, 32'd1);
        chk({tag, "_result"}, bus.rsp_result, res);
        chk({tag, "_zero"},   {31'b0, bus.rsp_zero}, {31'b0, zero});
        chk({tag, "_err"},    {31'b0, bus.rsp_err},  {31'b0, err});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_aluctl = 2'b00;
        bus.req_funct  = 6'h0;
        bus.req_shamt  = 5'h0;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.rsp_ready  = 1'b1;
        #1 reset = 1'b1;
        #2;
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_alu_reset", {31'b0, bus.alu_reset}, 32'd1);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_aluop",     {28'b0, bus.alu_aluop}, 32'd0);
        chk("rst_ina",       bus.alu_ina, 32'd0);
        chk("rst_inb",       bus.alu_inb, 32'd0);
        chk("rst_result",    bus.rsp_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_alu_reset_held", {31'b0, bus.alu_reset}, 32'd1);
        chk("rel_req_ready_held", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_alu_reset_drop", {31'b0, bus.alu_reset}, 32'd0);
        chk("rel_req_ready_rise", {31'b0, bus.req_ready}, 32'd1);

        // add 5+7 with cycle-accurate sequencing
        push(2'b00, 6'h0, 5'h0, 32'd5, 32'd7);
        @(posedge clk); #1;
        chk("add_e1_aluop", {28'b0, bus.alu_aluop}, 32'h2);
        chk("add_e1_ina",   bus.alu_ina, 32'd5);
        chk("add_e1_inb",   bus.alu_inb, 32'd0);
        chk("add_e1_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("add_e2_inb",   bus.alu_inb, 32'd7);
        chk("add_e2_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("add_e3_valid", {31'b0, bus.rsp_valid}, 32'd1);
        get_rsp("add", 32'd12, 1'b0, 1'b0);

        push(2'b01, 6'h0, 5'h0, 32'h1234, 32'h1234);
        get_rsp("sub", 32'd0, 1'b1, 1'b0);
        chk("sub_aluop", {28'b0, bus.alu_aluop}, 32'h6);

        push(2'b10, 6'h00, 5'd4, 32'hDEAD, 32'd1);
        get_rsp("sll", 32'd16, 1'b0, 1'b0);
        chk("sll_ina",   bus.alu_ina, 32'd1);
        chk("sll_inb",   bus.alu_inb, 32'd4);
        chk("sll_aluop", {28'b0, bus.alu_aluop}, 32'h8);

        push(2'b10, 6'h27, 5'h0, 32'h55, 32'h66);
        @(posedge clk); #1;
        chk("ill_e1_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("ill_e1_err",   {31'b0, bus.rsp_err}, 32'd1);
        get_rsp("illegal", 32'd0, 1'b0, 1'b1);
        chk("ill_ina",   bus.alu_ina, 32'd1);
        chk("ill_inb",   bus.alu_inb, 32'd4);
        chk("ill_aluop", {28'b0, bus.alu_aluop}, 32'h8);

        push(2'b11, 6'h20, 5'h0, 32'd1, 32'd2);
        get_rsp("ctl11", 32'd0, 1'b0, 1'b1);

        push(2'b10, 6'h2A, 5'h0, 32'hFFFF_FFFD, 32'd2);
`ifdef ALU_SLT_EN
        get_rsp("slt", 32'd1, 1'b0, 1'b0);
`else
        get_rsp("slt", 32'd0, 1'b0, 1'b1);
`endif

        // backpressure: two queued plus one in flight fills the path
        bus.rsp_ready = 1'b0;
        push(2'b10, 6'h24, 5'h0, 32'hF0, 32'h3C);
        push(2'b10, 6'h25, 5'h0, 32'h0F, 32'h30);
        push(2'b00, 6'h00, 5'h0, 32'd100, 32'd23);
        chk("bp_full_ready", {31'b0, bus.req_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_valid",  {31'b0, bus.rsp_valid}, 32'd1);
        chk("bp_hold_result", bus.rsp_result, 32'h30);
        chk("bp_hold_ready",  {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        get_rsp("bp_and", 32'h30, 1'b0, 1'b0);
        get_rsp("bp_or",  32'h3F, 1'b0, 1'b0);
        get_rsp("bp_add", 32'd123, 1'b0, 1'b0);

        // reset while one op is in WAIT and another is queued
        push(2'b00, 6'h0, 5'h0, 32'd9, 32'd9);
        push(2'b00, 6'h0, 5'h0, 32'd3, 32'd4);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("mid_alu_reset", {31'b0, bus.alu_reset}, 32'd1);
        chk("mid_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("mid_aluop",     {28'b0, bus.alu_aluop}, 32'd0);
        chk("mid_inb",       bus.alu_inb, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_alu_reset", {31'b0, bus.alu_reset}, 32'd0);
        chk("mid_rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_no_stale_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("mid_no_stale_inb",   bus.alu_inb, 32'd0);
        push(2'b00, 6'h0, 5'h0, 32'd1, 32'd1);
        get_rsp("post_reset_add", 32'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Initiator/control side of the combinational ALU port (ina, inb, aluop, reset in; result, zero out).
- Accepts decoded-instruction requests into a small FIFO, translates ALUOp/funct into the 4-bit aluop code, and drives the ALU port in a fixed sequence.
- Captures result/zero after a settle window and returns them on a valid/ready response channel.
- Sits between the main control unit and the ALU; used for multi-cycle and datapath bring-up.

Parameters:
- DEPTH, 2, request FIFO depth; power of 2, at least 2.
- SETTLE, 1, cycles between the inb update and result capture; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_aluctl  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = illegal.
- req_funct  in  6  MIPS funct field.
- req_shamt  in  5  shift amount.
- req_a  in  32  rs operand.
- req_b  in  32  rt operand.
- alu_ina  out  32  to ALU ina.
- alu_inb  out  32  to ALU inb.
- alu_aluop  out  4  to ALU aluop.
- alu_reset  out  1  to ALU reset (ALU evaluates only while low).
- alu_result  in  32  from ALU.
- alu_zero  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  illegal operation; no ALU launch.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - FIFO emptied, state IDLE, SETTLE counter cleared.
  - All data outputs 0; rsp_valid 0; alu_aluop 4'b0000; alu_reset 1; req_ready 0 while reset is asserted.
  - alu_reset is a flop: it drops to 0 on the first clock edge after reset deasserts; req_ready rises on that same edge.
- Push: an entry is written when req_valid and req_ready are both high at an edge. req_ready = (count != DEPTH), registered-count based. A push on a full FIFO cannot occur.
- Decode:
  - aluctl 00 -> 0010 (ADD); aluctl 01 -> 0110 (SUB).
  - aluctl 10 with funct 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x00 -> 1000 (SLL).
  - Every other funct, and aluctl 11, is illegal.
- Operand mapping:
  - SLL: alu_ina = req_b, alu_inb = {27'b0, req_shamt}.
  - Otherwise: alu_ina = req_a, alu_inb = req_b.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
  - IDLE, FIFO non-empty at an edge: pop the head entry.
    - Legal: drive alu_ina and alu_aluop; alu_inb is unchanged; go to LAUNCH.
    - Illegal: rsp_err=1, rsp_result=0, rsp_zero=0, rsp_valid=1; go to RESP; ALU outputs untouched.
  - LAUNCH: at the edge, drive alu_inb (inb always last), load counter=SETTLE, go to WAIT.
  - WAIT: decrement each edge. On the edge where the counter reads 1, register alu_result and alu_zero into rsp_result/rsp_zero, set rsp_err=0 and rsp_valid=1, go to RESP.
  - RESP: the response holds stable while rsp_valid && !rsp_ready. The edge with rsp_ready high clears rsp_valid and returns to IDLE. No pop occurs in that same edge.
- Push and pop in the same edge are allowed; count is unchanged.
- Pointers wrap modulo DEPTH.
- Latency, empty FIFO, SETTLE=1, rsp_ready held high:
  - Request accepted at edge E0; rsp_valid rises after E3 (legal) or after E1 (illegal).
  - Throughput is one response per 4 cycles (legal).
- ALU outputs hold their last driven values between operations.

Optional Feature:
- Macro: ALU_SLT_EN.
- Defined: funct 0x2A (slt) with aluctl 10 is legal.
  - Drives SUB with alu_ina=req_a, alu_inb=req_b, using the same sequence.
  - Capture writes rsp_result = {31'b0, signed(req_a) < signed(req_b)}, computed in-block from the latched operands.
  - rsp_zero = (rsp_result == 0).
- Undefined: funct 0x2A is illegal (rsp_err=1).

Test Plan:
- Reset, then add: aluctl=00, a=5, b=7 at E0, rsp_ready=1 -> alu_aluop=0010 after E1, alu_inb=7 after E2, rsp_valid after E3 with result=12, zero=0, err=0.
- Sub giving zero: aluctl=01, a=b=0x1234 -> aluop=0110, rsp_result=0, rsp_zero=1.
- SLL: aluctl=10, funct=0x00, b=1, shamt=4 -> alu_ina=1, alu_inb=4, rsp_result=16.
- Illegal op: aluctl=10, funct=0x27 -> rsp_err=1 one edge after the pop; alu_ina/inb/aluop unchanged from the previous op.
- Backpressure and full FIFO: DEPTH=2, rsp_ready=0, push 3 requests -> req_ready low after the third accept (2 queued plus 1 in flight). Raising rsp_ready drains in order AND (0xF0 & 0x3C = 0x30), OR (0x0F | 0x30 = 0x3F), ADD.
- Reset mid-WAIT: assert reset -> rsp_valid=0, alu_reset=1, FIFO empty. After release, a new add 1+1 returns 2 with no stale response.
